// File: rtl/regfile_context_engine_pkg.sv
// Shared types and sizing for the register-file context save/restore engine.
package regfile_context_engine_pkg;

  localparam int NUM_REGS = 31;  // r1..r31 move; r0 is hardwired and skipped
  localparam int DW       = 32;
  localparam int AW       = 10;
  localparam int RW       = 5;

  localparam logic [RW-1:0] IDX_FIRST = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] IDX_LAST  = RW'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } ctx_state_e;

  // Memory slot of register idx: base holds r1, so subtract one; wraps mod 2^AW.
  function automatic logic [AW-1:0] slot_addr(input logic [AW-1:0] base,
                                               input logic [RW-1:0] idx);
    return base + {{(AW-RW){1'b0}}, idx} - {{(AW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/regfile_context_engine_ctx_addr_gen.sv
// Register index counter and memory slot address generator.
module ctx_addr_gen
  import regfile_context_engine_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,   // operation accepted: restart at r1
  input  logic          step_i,   // one word moved this cycle
  input  logic [AW-1:0] base_i,
  output logic [RW-1:0] idx_o,
  output logic [AW-1:0] slot_o,
  output logic          last_o
);

  logic [RW-1:0] idx_q, idx_d;
  logic [AW-1:0] base_q, base_d;

  // Next index/base: restart on accept, advance while transferring, else hold.
  always_comb begin
    idx_d  = idx_q;
    base_d = base_q;
    if (load_i) begin
      idx_d  = IDX_FIRST;
      base_d = base_i;
    end else if (step_i) begin
      idx_d  = idx_q + IDX_FIRST;
    end else begin
      idx_d  = idx_q;
    end
  end

  // Counter and base latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= IDX_FIRST;
      base_q <= {AW{1'b0}};
    end else begin
      idx_q  <= idx_d;
      base_q <= base_d;
    end
  end

  assign idx_o  = idx_q;
  assign slot_o = slot_addr(base_q, idx_q);
  assign last_o = (idx_q == IDX_LAST);

endmodule

// File: rtl/regfile_context_engine.sv
// Moves r1..r31 to/from data memory one word per cycle, stalling the core.
module regfile_context_engine
  import regfile_context_engine_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          save_req,
  input  logic          restore_req,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic          op_is_save,
  output logic [RW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  ctx_state_e    state_q, state_d;
  logic          op_q, op_d;
  logic          accept_s;
  logic          step_s;
  logic [RW-1:0] idx_s;
  logic [AW-1:0] slot_s;
  logic          last_s;

  assign accept_s = (state_q == ST_IDLE) && (save_req || restore_req);
  assign step_s   = (state_q == ST_SAVE) || (state_q == ST_RESTORE);

  ctx_addr_gen u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept_s),
    .step_i (step_s),
    .base_i (base_addr),
    .idx_o  (idx_s),
    .slot_o (slot_s),
    .last_o (last_s)
  );

  // State and operation-type registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state: save has priority; requests outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (save_req) begin
          state_d = ST_SAVE;
          op_d    = 1'b1;
        end else if (restore_req) begin
          state_d = ST_RESTORE;
          op_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAVE: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_SAVE;
      end
      ST_RESTORE: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_RESTORE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from state and index; everything idles at zero.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rf_raddr  = {RW{1'b0}};
    rf_we     = 1'b0;
    rf_waddr  = {RW{1'b0}};
    rf_wdata  = {DW{1'b0}};
    mem_addr  = {AW{1'b0}};
    mem_we    = 1'b0;
    mem_wdata = {DW{1'b0}};
    case (state_q)
      ST_SAVE: begin
        busy      = 1'b1;
        rf_raddr  = idx_s;
        mem_addr  = slot_s;
        mem_wdata = rf_rdata;
        mem_we    = 1'b1;
      end
      ST_RESTORE: begin
        busy      = 1'b1;
        mem_addr  = slot_s;
        rf_waddr  = idx_s;
        rf_wdata  = mem_rdata;
        rf_we     = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ST_IDLE: begin
        busy = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign op_is_save = op_q;

endmodule

// File: tb/tb_regfile_context_engine.sv
// Directed bench: memory/register-file models around the context engine.
module tb_regfile_context_engine;
  import regfile_context_engine_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          save_req = 1'b0;
  logic          restore_req = 1'b0;
  logic [AW-1:0] base_addr = {AW{1'b0}};
  logic          busy, done, op_is_save, rf_we, mem_we;
  logic [RW-1:0] rf_raddr, rf_waddr;
  logic [DW-1:0] rf_rdata, rf_wdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] mem_init [0:1023];
  logic [DW-1:0] exp_mem [0:1023];
  logic [DW-1:0] rf [0:31];
  logic [DW-1:0] rf_init [0:31];
  logic [DW-1:0] exp_rf [0:31];
  logic          load_mem = 1'b0, load_rf = 1'b0, clr = 1'b0;
  int            mem_we_n, rf_we_n;
  logic          r0_wr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rf_rdata  = rf[rf_raddr];
  assign mem_rdata = mem[mem_addr];

  regfile_context_engine dut (
    .clk(clk), .rst_n(rst_n), .save_req(save_req), .restore_req(restore_req),
    .base_addr(base_addr), .busy(busy), .done(done), .op_is_save(op_is_save),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory and register-file models plus write activity counters.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= mem_init[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (load_rf) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init[i];
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
    if (clr) begin
      mem_we_n <= 0;
      rf_we_n  <= 0;
      r0_wr    <= 1'b0;
    end else begin
      if (mem_we) mem_we_n <= mem_we_n + 1;
      if (rf_we)  rf_we_n  <= rf_we_n + 1;
      if (rf_we && rf_waddr == 5'd0) r0_wr <= 1'b1;
    end
  end

  typedef struct {
    logic          s;
    logic          r;
    logic [AW-1:0] base;
    logic          exp_busy;
    logic          exp_op;
    logic          exp_mem_we;
    logic          exp_rf_we;
    logic [AW-1:0] exp_addr;
    logic [RW-1:0] exp_raddr;
    logic [RW-1:0] exp_waddr;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic bg_fill();
    for (int i = 0; i < 1024; i++) begin
      mem_init[i] = 32'hC0DE_0000 | 32'(i);
      exp_mem[i]  = 32'hC0DE_0000 | 32'(i);
    end
  endtask

  task automatic commit(input logic do_rf);
    @(negedge clk);
    load_mem = 1'b1;
    load_rf  = do_rf;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    load_mem = 1'b0;
    load_rf  = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic mem_compare(input string name);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic run_op(input logic s, input logic r, input logic [AW-1:0] b,
                        input bit mid_restore, output int busy_n, output int done_at,
                        output logic op_seen);
    @(negedge clk);
    save_req = s; restore_req = r; base_addr = b;
    @(posedge clk);
    #1;
    save_req = 1'b0; restore_req = 1'b0;
    busy_n = 0; done_at = -1; op_seen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) op_seen = op_is_save;
      if (busy) busy_n++;
      if (done) done_at = c;
      if (mid_restore) restore_req = (c >= 5 && c <= 8);
      if (!busy) break;
    end
    restore_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, da, bad, k;
    logic op;

    vecs[0] = '{1'b0, 1'b0, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 5'd0, 5'd0};
    vecs[1] = '{1'b1, 1'b0, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, 10'd5, 5'd1, 5'd0};
    vecs[2] = '{1'b0, 1'b1, 10'd7, 1'b1, 1'b0, 1'b0, 1'b1, 10'd7, 5'd0, 5'd1};
    vecs[3] = '{1'b1, 1'b1, 10'd9, 1'b1, 1'b1, 1'b1, 1'b0, 10'd9, 5'd1, 5'd0};

    // Reset state
    bg_fill();
    for (int i = 0; i < 32; i++) rf_init[i] = 32'hA000_0000 + 32'(i);
    rf_init[0] = 32'd0;
    commit(1'b1);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_op", {31'd0, op_is_save}, 32'd0);
    chk("rst_we", {30'd0, mem_we, rf_we}, 32'd0);
    chk("rst_addr", {12'd0, mem_addr, rf_raddr, rf_waddr}, 32'd0);
    chk("rst_data", mem_wdata | rf_wdata, 32'd0);
    rst_n = 1'b1;

    // Table: first-cycle decode after a request, then drain to idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      save_req = vecs[i].s; restore_req = vecs[i].r; base_addr = vecs[i].base;
      @(posedge clk);
      #1;
      save_req = 1'b0; restore_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      chk($sformatf("v%0d_op", i), {31'd0, op_is_save}, {31'd0, vecs[i].exp_op});
      chk($sformatf("v%0d_we", i), {30'd0, mem_we, rf_we},
          {30'd0, vecs[i].exp_mem_we, vecs[i].exp_rf_we});
      chk($sformatf("v%0d_addr", i), {12'd0, mem_addr, rf_raddr, rf_waddr},
          {12'd0, vecs[i].exp_addr, vecs[i].exp_raddr, vecs[i].exp_waddr});
      k = 0;
      while (busy && k < 50) begin @(negedge clk); k++; end
      chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
    end

    // 1: SAVE at 100
    bg_fill();
    for (int i = 0; i < 32; i++) rf_init[i] = 32'hA000_0000 + 32'(i);
    rf_init[0] = 32'd0;
    commit(1'b1);
    run_op(1'b1, 1'b0, 10'd100, 1'b0, bn, da, op);
    for (int j = 1; j <= 31; j++) exp_mem[100 + j - 1] = 32'hA000_0000 + 32'(j);
    chk("t1_done_at", 32'(da), 32'd32);
    chk("t1_busy_cycles", 32'(bn), 32'd32);
    chk("t1_mem_we_cycles", 32'(mem_we_n), 32'd31);
    chk("t1_op", {31'd0, op}, 32'd1);
    mem_compare("t1_mem");

    // 2: RESTORE from 200
    bg_fill();
    for (int j = 0; j < 31; j++) mem_init[200 + j] = 32'h5500_0000 + 32'(j);
    for (int i = 0; i < 32; i++) rf_init[i] = 32'h1111_0000;
    commit(1'b1);
    run_op(1'b0, 1'b1, 10'd200, 1'b0, bn, da, op);
    bad = 0;
    for (int j = 0; j < 31; j++) if (rf[j + 1] !== 32'h5500_0000 + 32'(j)) bad++;
    chk("t2_rf", 32'(bad), 32'd0);
    chk("t2_r0", rf[0], 32'h1111_0000);
    chk("t2_r0_wr", {31'd0, r0_wr}, 32'd0);
    chk("t2_rf_we_cycles", 32'(rf_we_n), 32'd31);
    chk("t2_mem_we_cycles", 32'(mem_we_n), 32'd0);
    chk("t2_done_at", 32'(da), 32'd32);
    chk("t2_op", {31'd0, op}, 32'd0);

    // 3: simultaneous requests, restore raised mid-SAVE
    bg_fill();
    commit(1'b0);
    run_op(1'b1, 1'b1, 10'd400, 1'b1, bn, da, op);
    for (int j = 1; j <= 31; j++) exp_mem[400 + j - 1] = 32'h5500_0000 + 32'(j - 1);
    chk("t3_op", {31'd0, op}, 32'd1);
    chk("t3_rf_we_cycles", 32'(rf_we_n), 32'd0);
    chk("t3_mem_we_cycles", 32'(mem_we_n), 32'd31);
    chk("t3_busy_cycles", 32'(bn), 32'd32);
    repeat (3) @(negedge clk);
    chk("t3_not_queued", {31'd0, busy}, 32'd0);
    mem_compare("t3_mem");

    // 4: address wrap from 1010
    bg_fill();
    commit(1'b0);
    run_op(1'b1, 1'b0, 10'd1010, 1'b0, bn, da, op);
    for (int j = 1; j <= 31; j++) exp_mem[(1010 + j - 1) & 1023] = 32'h5500_0000 + 32'(j - 1);
    chk("t4_mem_we_cycles", 32'(mem_we_n), 32'd31);
    chk("t4_done_at", 32'(da), 32'd32);
    mem_compare("t4_mem");

    // 5: reset during SAVE at idx 10
    bg_fill();
    commit(1'b0);
    @(negedge clk);
    save_req = 1'b1; base_addr = 10'd500;
    @(posedge clk);
    #1;
    save_req = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    chk("t5_idx10", {27'd0, rf_raddr}, 32'd10);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("t5_rst_we", {30'd0, mem_we, rf_we}, 32'd0);
    chk("t5_rst_addr", {12'd0, mem_addr, rf_raddr, rf_waddr}, 32'd0);
    chk("t5_rst_op", {31'd0, op_is_save}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 9; j++) exp_mem[500 + j - 1] = 32'h5500_0000 + 32'(j - 1);
    chk("t5_mem_we_cycles", 32'(mem_we_n), 32'd9);
    mem_compare("t5_mem_partial");
    run_op(1'b1, 1'b0, 10'd500, 1'b0, bn, da, op);
    for (int j = 1; j <= 31; j++) exp_mem[500 + j - 1] = 32'h5500_0000 + 32'(j - 1);
    chk("t5_after_done_at", 32'(da), 32'd32);
    mem_compare("t5_mem_after");

    // 6: round trip through base 300
    bg_fill();
    for (int i = 1; i < 32; i++) begin
      exp_rf[i]  = $urandom;
      rf_init[i] = exp_rf[i];
    end
    rf_init[0] = 32'd0;
    commit(1'b1);
    run_op(1'b1, 1'b0, 10'd300, 1'b0, bn, da, op);
    for (int i = 1; i < 32; i++) rf_init[i] = ~exp_rf[i];
    @(negedge clk);
    load_rf = 1'b1;
    @(posedge clk);
    #1;
    load_rf = 1'b0;
    run_op(1'b0, 1'b1, 10'd300, 1'b0, bn, da, op);
    bad = 0;
    for (int i = 1; i < 32; i++) if (rf[i] !== exp_rf[i]) bad++;
    chk("t6_roundtrip", 32'(bad), 32'd0);
    chk("t6_r0", rf[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
